// File: rtl/prnd_dither_ctrl.sv
// prnd_dither_ctrl: paces PRND generator ticks, ramps the dither range
// toward its target, and forms the saturated dithered DCO code.
module prnd_dither_ctrl #(
  parameter int NUM_PRND_BITS = 5,
  parameter int NUM_CODE_BITS = 8,
  parameter int NUM_DIV_BITS  = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     ditherEn,
  input  logic [NUM_PRND_BITS:0]   targetRange,
  input  logic [NUM_DIV_BITS-1:0]  updatePeriod,
  input  logic [NUM_CODE_BITS-1:0] baseCode,
  input  logic [NUM_PRND_BITS-1:0] prndNum,
  output logic                     prndEnable,
  output logic [NUM_PRND_BITS:0]   prndRange,
  output logic [NUM_CODE_BITS-1:0] ditherCode,
  output logic                     codeValid,
  output logic [1:0]               state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    DITHER    = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  localparam int RW = NUM_PRND_BITS + 1;
  localparam int SW = NUM_CODE_BITS + 2;
  localparam logic [RW-1:0] MAX_RANGE =
    {1'b1, {NUM_PRND_BITS{1'b0}}};
  localparam logic signed [SW-1:0] CODE_MAX =
    {2'b00, {NUM_CODE_BITS{1'b1}}};

  state_t                   st;
  state_t                   next_st;
  logic [RW-1:0]            cur_range;
  logic [RW-1:0]            desired;
  logic [RW-1:0]            next_range;
  logic [NUM_DIV_BITS-1:0]  cnt;
  logic [NUM_DIV_BITS-1:0]  period;
  logic [1:0]               cap_pipe;
  logic                     tick;
  logic signed [SW-1:0]     sum;
  logic [NUM_CODE_BITS-1:0] code_next;

  assign period = (updatePeriod < NUM_DIV_BITS'(2)) ?
                  NUM_DIV_BITS'(2) : updatePeriod;
  assign tick = (st != IDLE) && (cnt == '0);

  assign prndEnable = tick;
  assign prndRange  = cur_range;
  assign state      = st;

  always_comb begin
    desired = '0;
    if (ditherEn)
      desired = (targetRange > MAX_RANGE) ?
                MAX_RANGE : targetRange;
  end

  always_comb begin
    next_range = cur_range;
    unique case (1'b1)
      cur_range < desired: next_range = cur_range + 1'b1;
      cur_range > desired: next_range = cur_range - 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    next_st = RAMP_DOWN;
    unique case (1'b1)
      (next_range == '0) && !ditherEn:
        next_st = IDLE;
      next_range < desired:
        next_st = RAMP_UP;
      (next_range == desired) && ditherEn:
        next_st = DITHER;
      next_range > desired:
        next_st = RAMP_DOWN;
      default: ;
    endcase
  end

  // zero-centred offset: prndNum spans [0, range), so subtract range/2
  always_comb begin
    sum = $signed({2'b00, baseCode})
        + $signed(SW'(prndNum))
        - $signed(SW'(cur_range >> 1));
    code_next = sum[NUM_CODE_BITS-1:0];
    if (cur_range == '0)
      code_next = baseCode;
    else if (sum[SW-1])
      code_next = '0;
    else if (sum > CODE_MAX)
      code_next = '1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st         <= IDLE;
      cur_range  <= '0;
      cnt        <= '0;
      cap_pipe   <= '0;
      ditherCode <= '0;
      codeValid  <= 1'b0;
    end else begin
      cap_pipe  <= {cap_pipe[0], tick};
      codeValid <= cap_pipe[1];
      if (cap_pipe[1])
        ditherCode <= code_next;
      else if ((st == IDLE) && (cap_pipe == '0))
        ditherCode <= baseCode;
      if (st == IDLE) begin
        if (ditherEn) begin
          cnt <= period;
          st  <= (desired == '0) ? DITHER : RAMP_UP;
        end
      end else if (tick) begin
        cnt       <= period;
        cur_range <= next_range;
        st        <= next_st;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prnd_dither_ctrl.sv
// tb_prnd_dither_ctrl: directed vectors with a queue scoreboard;
// a negedge monitor checks ticks and every codeValid sample.
module tb_prnd_dither_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ditherEn = 1'b1;
  logic [5:0] targetRange = '0;
  logic [7:0] updatePeriod = 8'd3;
  logic [7:0] baseCode = '0;
  logic [4:0] prndNum = '0;
  logic       prndEnable;
  logic [5:0] prndRange;
  logic [7:0] ditherCode;
  logic       codeValid;
  logic [1:0] state;

  prnd_dither_ctrl dut (
    .clock(clock), .reset(reset), .ditherEn(ditherEn),
    .targetRange(targetRange), .updatePeriod(updatePeriod),
    .baseCode(baseCode), .prndNum(prndNum),
    .prndEnable(prndEnable), .prndRange(prndRange),
    .ditherCode(ditherCode), .codeValid(codeValid),
    .state(state)
  );

  always #5 clock = ~clock;

  typedef struct {
    int gap;
    int rng;
    int st;
  } tick_t;

  tick_t tq[$];
  int    cq[$];
  int    total = 0;
  int    passed = 0;
  int    nticks = 0;
  int    exp_ticks = 0;
  int    gap_exp = 4;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic fail(input string name);
    total++;
    $display("FAIL %s: got event, expected none", name);
  endtask

  // monitor
  tick_t      cur;
  logic       pend = 1'b0;
  logic [2:0] hist = '0;
  int         gapc = 0;

  always @(negedge clock) begin
    if (reset) begin
      pend = 1'b0;
      hist = '0;
      gapc = 0;
    end else begin
      if (pend) begin
        pend = 1'b0;
        chk("tick_range", int'(prndRange), cur.rng);
        chk("tick_state", int'(state), cur.st);
      end
      if (prndEnable) begin
        nticks++;
        if (tq.size() == 0) fail("tick_unexpected");
        else begin
          cur = tq.pop_front();
          if (cur.gap != 0) chk("tick_gap", gapc, cur.gap);
          pend = 1'b1;
        end
      end
      if (codeValid) begin
        chk("cv_latency", int'(hist[2]), 1);
        if (cq.size() == 0) fail("code_unexpected");
        else chk("dither_code", int'(ditherCode), cq.pop_front());
      end
      hist = {hist[1:0], prndEnable};
      gapc = prndEnable ? 1 : gapc + 1;
    end
  end

  task automatic wait_tick();
    bit got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clock);
      got = prndEnable;
    end
    if (!got) fail("tick_timeout");
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input int b, input int p,
                        input int e, input int t);
    baseCode    = 8'(b);
    prndNum     = 5'(p);
    ditherEn    = 1'(e);
    targetRange = 6'(t);
  endtask

  task automatic start(input int b, input int p, input int e,
                       input int t, input int u,
                       input int nr, input int ns);
    set_in(b, p, e, t);
    updatePeriod = 8'(u);
    tq.push_back('{0, nr, ns});
    exp_ticks++;
    wait_tick();
  endtask

  task automatic step(input int b, input int p, input int e,
                      input int t, input int code,
                      input int nr, input int ns);
    set_in(b, p, e, t);
    cq.push_back(code);
    tq.push_back('{gap_exp, nr, ns});
    exp_ticks++;
    wait_tick();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_en"}, int'(prndEnable), 0);
    chk({tag, "_range"}, int'(prndRange), 0);
    chk({tag, "_code"}, int'(ditherCode), 0);
    chk({tag, "_valid"}, int'(codeValid), 0);
    chk({tag, "_state"}, int'(state), 0);
  endtask

  // base, prnd, en, target, code of last tick, next range, next state
  int va [0:22][0:6] = '{
    '{100, 3, 1, 4, 103, 2, 1},
    '{100, 3, 1, 4, 102, 3, 1},
    '{100, 3, 1, 4, 102, 4, 2},
    '{100, 3, 1, 4, 101, 4, 2},
    '{  0, 0, 1, 8,   0, 5, 1},
    '{  0, 0, 1, 8,   0, 6, 1},
    '{255, 7, 1, 8, 255, 7, 1},
    '{255, 7, 1, 8, 255, 8, 2},
    '{255, 7, 1, 8, 255, 8, 2},
    '{  0, 0, 1, 8,   0, 8, 2},
    '{100, 1, 1, 6,  97, 7, 3},
    '{100, 1, 1, 6,  98, 6, 2},
    '{100, 1, 1, 3,  98, 5, 3},
    '{100, 1, 1, 3,  99, 4, 3},
    '{100, 1, 1, 3,  99, 3, 2},
    '{100, 2, 1, 4, 101, 4, 2},
    '{100, 2, 1, 4, 100, 4, 2},
    '{100, 2, 0, 4, 100, 3, 3},
    '{100, 2, 0, 4, 101, 2, 3},
    '{100, 2, 1, 4, 101, 3, 1},
    '{ 50, 0, 0, 4,  49, 2, 3},
    '{ 50, 0, 0, 4,  49, 1, 3},
    '{ 50, 0, 0, 4,  50, 0, 0}
  };

  int saved;

  initial begin
    #12;
    chk_zero("rst0");
    ditherEn = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;

    // ramp up, saturation, retarget, ramp down, re-assert
    gap_exp = 4;
    start(100, 3, 1, 4, 3, 1, 1);
    foreach (va[i])
      step(va[i][0], va[i][1], va[i][2], va[i][3],
           va[i][4], va[i][5], va[i][6]);
    baseCode = 8'd50;
    prndNum  = 5'd31;
    cq.push_back(50);
    repeat (20) @(posedge clock);
    #1;
    chk("idle_tick_count", nticks, exp_ticks);
    chk("idle_state", int'(state), 0);
    chk("idle_code_q", cq.size(), 0);
    baseCode = 8'd77;
    @(posedge clock);
    #1;
    chk("idle_track_a", int'(ditherCode), 77);
    baseCode = 8'd200;
    @(posedge clock);
    #1;
    chk("idle_track_b", int'(ditherCode), 200);

    // updatePeriod=0 acts as 2, targetRange=63 clamps to 32
    gap_exp = 3;
    start(128, 16, 1, 63, 0, 1, 1);
    for (int r = 1; r <= 32; r++)
      step(128, 16, 1, 63, 144 - r / 2,
           (r < 32) ? r + 1 : 32, (r + 1 >= 32) ? 2 : 1);

    // asynchronous reset mid-cycle while dithering
    #2;
    reset = 1'b1;
    #1;
    chk_zero("rst1");
    tq.delete();
    cq.delete();
    saved = nticks;
    repeat (3) begin
      @(negedge clock);
      chk("rst_no_tick", int'(prndEnable), 0);
    end
    ditherEn = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    chk("post_rst_ticks", nticks, saved);
    chk("post_rst_state", int'(state), 0);
    chk("post_rst_range", int'(prndRange), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
